sr_drive_sequencer: RTL and testbench

- Upstream driver for the gated SR latch: turns single-cycle set/clear requests into clean, timed S/R pulses plus the clock/enable strobe.
- Never drives the forbidden S=R=1 combination.
- Enforces a guard gap of S=R=0 between commands and queues one pending request.
- Checks the latch's Q feedback after each command and flags any mismatch.

---
 rtl/sr_drive_sequencer_pkg.sv | 14 +
 rtl/sr_drive_sequencer_if.sv | 23 ++
 rtl/sr_drive_sequencer_pending_slot.sv | 39 +++
 rtl/sr_drive_sequencer.sv | 114 +++++++++++
 tb/tb_sr_drive_sequencer.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/sr_drive_sequencer_pkg.sv
// sr_pkg: shared encodings and counter helpers for the SR latch drive sequencer
package sr_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;
    localparam logic CMD_CLR = 1'b0;
    localparam logic CMD_SET = 1'b1;
    localparam int CNT_W = 4;
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction
endpackage

// File: rtl/sr_drive_sequencer_if.sv
// sr_drive_sequencer_if: request, latch drive and status bundle of the sequencer
interface sr_drive_sequencer_if;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s;
    logic r;
    logic en;
    logic busy;
    logic exp_q;
    logic exp_valid;
    logic mismatch;
    logic overrun;
    logic conflict;
    modport master (
        output set_req, clr_req, q_fb,
        input  s, r, en, busy, exp_q, exp_valid, mismatch, overrun, conflict
    );
    modport slave (
        input  set_req, clr_req, q_fb,
        output s, r, en, busy, exp_q, exp_valid, mismatch, overrun, conflict
    );
endinterface

// File: rtl/sr_drive_sequencer_pending_slot.sv
// sr_pending_slot: one-deep holder for a request that arrives while the sequencer is busy
module sr_pending_slot
    import sr_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic req_valid,
    input  logic req_cmd,
    input  logic hold,
    input  logic consume,
    output logic full,
    output logic cmd,
    output logic overrun
);
    logic full_q, full_d, cmd_q, cmd_d, overrun_q, overrun_d, capture, drop;
    // A request made while holding fills an empty slot or is dropped against a full one
    always_comb begin
        capture   = req_valid & hold & ~full_q;
        drop      = req_valid & hold & full_q;
        full_d    = capture | (full_q & ~consume);
        cmd_d     = capture ? req_cmd : cmd_q;
        overrun_d = drop;
    end
    // Slot state and the one-cycle overrun pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q    <= 1'b0;
            cmd_q     <= CMD_CLR;
            overrun_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            cmd_q     <= cmd_d;
            overrun_q <= overrun_d;
        end
    end
    assign full    = full_q;
    assign cmd     = cmd_q;
    assign overrun = overrun_q;
endmodule

// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: turns set/clear requests into guarded S/R/en pulses and checks latch feedback
module sr_drive_sequencer
    import sr_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    sr_drive_sequencer_if.slave bus
);
    localparam logic [CNT_W-1:0] PULSE_LD = cnt_load(PULSE_CYCLES);
    localparam logic [CNT_W-1:0] GUARD_LD = cnt_load(GUARD_CYCLES);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_q, cmd_d;
    logic             s_q, s_d, r_q, r_d, en_q, en_d;
    logic             exp_q_q, exp_q_d, exp_valid_q, exp_valid_d;
    logic             mismatch_q, mismatch_d, conflict_q, conflict_d;
    logic             req_valid, req_cmd, consume, pend_full, pend_cmd, pend_overrun, hold;
    assign req_valid = bus.set_req ^ bus.clr_req;
    assign req_cmd   = bus.set_req ? CMD_SET : CMD_CLR;
    assign hold      = (state_q != ST_IDLE) | pend_full;
    sr_pending_slot u_slot (
        .clock    (clock),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_cmd  (req_cmd),
        .hold     (hold),
        .consume  (consume),
        .full     (pend_full),
        .cmd      (pend_cmd),
        .overrun  (pend_overrun)
    );
    // Next-state: launch, count down pulse and guard, then record/check and chain or idle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_d       = cmd_q;
        exp_q_d     = exp_q_q;
        exp_valid_d = exp_valid_q;
        mismatch_d  = mismatch_q;
        consume     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pend_full) begin
                state_d = ST_DRIVE;
                cnt_d   = PULSE_LD;
                cmd_d   = pend_cmd;
                consume = 1'b1;
            end else if (req_valid) begin
                state_d = ST_DRIVE;
                cnt_d   = PULSE_LD;
                cmd_d   = req_cmd;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (state_q == ST_DRIVE) begin
            state_d = ST_GUARD;
            cnt_d   = GUARD_LD;
        end else begin
            exp_q_d     = cmd_q;
            exp_valid_d = 1'b1;
            mismatch_d  = mismatch_q | (bus.q_fb != cmd_q);
            consume     = pend_full;
            if (pend_full) begin
                state_d = ST_DRIVE;
                cnt_d   = PULSE_LD;
                cmd_d   = pend_cmd;
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
        en_d       = state_d == ST_DRIVE;
        s_d        = en_d & (cmd_d == CMD_SET);
        r_d        = en_d & (cmd_d == CMD_CLR);
        conflict_d = bus.set_req & bus.clr_req;
    end
    // Registered FSM state and outputs; reset drops the drive at once with no completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_q       <= CMD_CLR;
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            en_q        <= 1'b0;
            exp_q_q     <= 1'b0;
            exp_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            s_q         <= s_d;
            r_q         <= r_d;
            en_q        <= en_d;
            exp_q_q     <= exp_q_d;
            exp_valid_q <= exp_valid_d;
            mismatch_q  <= mismatch_d;
            conflict_q  <= conflict_d;
        end
    end
    assign bus.s         = s_q;
    assign bus.r         = r_q;
    assign bus.en        = en_q;
    assign bus.busy      = state_q != ST_IDLE;
    assign bus.exp_q     = exp_q_q;
    assign bus.exp_valid = exp_valid_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.overrun   = pend_overrun;
    assign bus.conflict  = conflict_q;
endmodule

// File: tb/tb_sr_drive_sequencer.sv
// tb_sr_drive_sequencer: directed checks of the sequencer driving a behavioural gated SR latch
module tb_sr_drive_sequencer;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic q_latch = 1'b0;
    logic force_low = 1'b0;
    logic sr_bad = 1'b0;
    logic en_bad = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    sr_drive_sequencer_if bus();
    sr_drive_sequencer #(.PULSE_CYCLES(2), .GUARD_CYCLES(1)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );
    always #5 clock = ~clock;
    // Gated SR latch: transparent while en, holds otherwise
    always @(bus.s or bus.r or bus.en) begin
        if (bus.en && bus.s) q_latch = 1'b1;
        else if (bus.en && bus.r) q_latch = 1'b0;
    end
    assign bus.q_fb = force_low ? 1'b0 : q_latch;
    // Invariant watch on settled outputs
    always @(negedge clock) begin
        if (bus.s && bus.r) sr_bad = 1'b1;
        if (bus.en !== (bus.s | bus.r)) en_bad = 1'b1;
    end
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic req(input logic set_i, input logic clr_i);
        bus.set_req = set_i;
        bus.clr_req = clr_i;
        tick();
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
    endtask
    task automatic do_reset();
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        do_reset();
        check("rst s", bus.s, 0);
        check("rst r", bus.r, 0);
        check("rst en", bus.en, 0);
        check("rst busy", bus.busy, 0);
        check("rst exp_valid", bus.exp_valid, 0);
        check("rst mismatch", bus.mismatch, 0);
        // single set command
        req(1, 0);
        check("t1 c1 s", bus.s, 1);
        check("t1 c1 en", bus.en, 1);
        check("t1 c1 busy", bus.busy, 1);
        tick();
        check("t1 c2 s", bus.s, 1);
        tick();
        check("t1 c3 s", bus.s, 0);
        check("t1 c3 en", bus.en, 0);
        check("t1 c3 busy", bus.busy, 1);
        check("t1 c3 exp_valid", bus.exp_valid, 0);
        tick();
        check("t1 c4 exp_q", bus.exp_q, 1);
        check("t1 c4 exp_valid", bus.exp_valid, 1);
        check("t1 c4 mismatch", bus.mismatch, 0);
        check("t1 c4 busy", bus.busy, 0);
        // set then queued clear, chained without idle
        do_reset();
        req(1, 0);
        req(0, 1);
        check("t2 c2 s", bus.s, 1);
        tick();
        check("t2 c3 s", bus.s, 0);
        check("t2 c3 r", bus.r, 0);
        tick();
        check("t2 c4 r", bus.r, 1);
        check("t2 c4 en", bus.en, 1);
        check("t2 c4 busy", bus.busy, 1);
        check("t2 c4 exp_q", bus.exp_q, 1);
        tick(3);
        check("t2 c7 exp_q", bus.exp_q, 0);
        check("t2 c7 busy", bus.busy, 0);
        check("t2 c7 mismatch", bus.mismatch, 0);
        // third request overruns the full slot
        do_reset();
        req(1, 0);
        req(0, 1);
        check("t3 c2 overrun", bus.overrun, 0);
        req(1, 0);
        check("t3 c3 overrun", bus.overrun, 1);
        tick();
        check("t3 c4 overrun", bus.overrun, 0);
        check("t3 c4 r", bus.r, 1);
        tick(3);
        check("t3 c7 busy", bus.busy, 0);
        check("t3 c7 exp_q", bus.exp_q, 0);
        tick(3);
        check("t3 c10 busy", bus.busy, 0);
        check("t3 c10 s", bus.s, 0);
        // simultaneous set and clear
        do_reset();
        req(1, 1);
        check("t4 conflict", bus.conflict, 1);
        check("t4 s", bus.s, 0);
        check("t4 r", bus.r, 0);
        check("t4 busy", bus.busy, 0);
        check("t4 overrun", bus.overrun, 0);
        tick();
        check("t4 conflict drop", bus.conflict, 0);
        check("t4 busy later", bus.busy, 0);
        check("t4 exp_valid", bus.exp_valid, 0);
        // stuck-low feedback makes mismatch stick until reset
        do_reset();
        force_low = 1'b1;
        req(1, 0);
        tick(3);
        check("t5 mismatch set", bus.mismatch, 1);
        check("t5 exp_q", bus.exp_q, 1);
        force_low = 1'b0;
        req(0, 1);
        tick(3);
        check("t5 mismatch held1", bus.mismatch, 1);
        check("t5 exp_q clr", bus.exp_q, 0);
        req(1, 0);
        tick(3);
        check("t5 mismatch held2", bus.mismatch, 1);
        reset_n = 1'b0;
        #1;
        check("t5 mismatch rst", bus.mismatch, 0);
        tick();
        // reset mid-pulse with a queued request
        do_reset();
        req(1, 0);
        req(0, 1);
        check("t6 c2 s", bus.s, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 async s", bus.s, 0);
        check("t6 async en", bus.en, 0);
        check("t6 async busy", bus.busy, 0);
        tick();
        reset_n = 1'b1;
        tick(4);
        check("t6 busy", bus.busy, 0);
        check("t6 exp_valid", bus.exp_valid, 0);
        check("t6 r", bus.r, 0);
        check("inv s&r", sr_bad, 0);
        check("inv en", en_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
